// File: rtl/stopwatch_alarm_timer.sv
// mm:ss.cc stopwatch / countdown timer with sticky alarm and lap freeze.
// Cascaded BCD counter drives six active-low seven-segment displays.
module stopwatch_alarm_timer #(
  parameter int CLK_DIV   = 500000,
  parameter int BLINK_DIV = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  input  logic        load,
  input  logic [23:0] load_digits,
  input  logic        count_down,
  input  logic        alarm_en,
  input  logic [23:0] alarm_digits,
  input  logic        alarm_ack,
  output logic [23:0] digits,
  output logic        running,
  output logic        frozen,
  output logic        alarm,
  output logic [7:0]  hex5,
  output logic [7:0]  hex4,
  output logic [7:0]  hex3,
  output logic [7:0]  hex2,
  output logic [7:0]  hex1,
  output logic [7:0]  hex0
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);
  localparam logic [23:0] DMAX = 24'h995999;

  logic [PW-1:0] r_presc;
  logic [23:0]   r_digits;
  logic [23:0]   r_snap;
  logic          r_running;
  logic          r_frozen;
  logic          r_alarm;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_off;
  logic [7:0]    r_hex [6];

  logic          w_tick;
  logic          w_count;
  logic          w_load_act;
  logic          w_zero;
  logic          w_at_max;
  logic          w_alarm_set;
  logic          w_blank;
  logic [23:0]   w_up;
  logic [23:0]   w_dn;
  logic [23:0]   w_load;
  logic [23:0]   w_src;

  // Largest legal value of digit i; d3 is the seconds tens digit.
  function automatic logic [3:0] dig_max(input int i);
    return (i == 3) ? 4'd5 : 4'd9;
  endfunction

  // Active-low segments g..a for one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign w_tick     = (r_presc == PMAX);
  assign w_zero     = (r_digits == 24'h0);
  assign w_at_max   = (r_digits == DMAX);
  assign w_load_act = load & ~r_running & ~clear;
  assign w_count    = r_running & w_tick & ~clear & ~start_stop;

  // Mixed-radix increment, decrement and load clamp of the digit chain.
  always_comb begin
    logic cy;
    logic bw;
    w_up   = r_digits;
    w_dn   = r_digits;
    w_load = load_digits;
    cy     = 1'b1;
    bw     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (cy) begin
        if (r_digits[4*i +: 4] >= dig_max(i)) begin
          w_up[4*i +: 4] = 4'd0;
        end else begin
          w_up[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
          cy = 1'b0;
        end
      end
      if (bw) begin
        if (r_digits[4*i +: 4] == 4'd0) begin
          w_dn[4*i +: 4] = dig_max(i);
        end else begin
          w_dn[4*i +: 4] = r_digits[4*i +: 4] - 4'd1;
          bw = 1'b0;
        end
      end
      if (load_digits[4*i +: 4] > dig_max(i))
        w_load[4*i +: 4] = dig_max(i);
    end
  end

  // Alarm fires when a down count lands on (or sits at) zero, or an up
  // count steps onto the compare value.
  always_comb begin
    w_alarm_set = 1'b0;
    if (w_count && alarm_en) begin
      if (count_down)
        w_alarm_set = w_zero | (w_dn == 24'h0);
      else
        w_alarm_set = ~w_at_max & (w_up == alarm_digits);
    end
  end

  // Free-running centisecond prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_presc <= '0;
    else if (w_tick)
      r_presc <= '0;
    else
      r_presc <= r_presc + 1'b1;
  end

  // Count register and run flag: clear > load > start_stop > tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digits  <= '0;
      r_running <= 1'b0;
    end else if (clear) begin
      r_digits  <= '0;
      r_running <= 1'b0;
    end else if (w_load_act) begin
      r_digits  <= w_load;
    end else if (start_stop) begin
      r_running <= ~r_running;
    end else if (w_count) begin
      if (count_down) begin
        if (w_zero) begin
          r_running <= 1'b0;
        end else begin
          r_digits <= w_dn;
          if (w_dn == 24'h0)
            r_running <= 1'b0;
        end
      end else begin
        if (w_at_max)
          r_running <= 1'b0;
        else
          r_digits <= w_up;
      end
    end
  end

  // Lap freeze toggle with snapshot of the live count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frozen <= 1'b0;
      r_snap   <= '0;
    end else if (clear) begin
      r_frozen <= 1'b0;
    end else if (lap && r_running) begin
      r_frozen <= ~r_frozen;
      if (!r_frozen)
        r_snap <= r_digits;
    end
  end

  // Sticky alarm; a new set wins over a same-cycle acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_alarm <= 1'b0;
    else if (clear)
      r_alarm <= 1'b0;
    else if (w_alarm_set)
      r_alarm <= 1'b1;
    else if (alarm_ack)
      r_alarm <= 1'b0;
  end

  // Blink phase: held at "on" while idle, toggles every BLINK_DIV ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (!r_alarm || w_load_act) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == BMAX) begin
        r_blink_cnt <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_src   = r_frozen ? r_snap : r_digits;
  assign w_blank = r_alarm & r_blink_off;

  // Registered segment drive; dp lit after minutes and seconds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++)
        r_hex[i] <= (i == 2 || i == 4) ? 8'h40 : 8'hC0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (w_blank)
          r_hex[i] <= 8'hFF;
        else
          r_hex[i] <= {~(i == 2 || i == 4), seg7(w_src[4*i +: 4])};
      end
    end
  end

  assign digits  = r_digits;
  assign running = r_running;
  assign frozen  = r_frozen;
  assign alarm   = r_alarm;
  assign hex0    = r_hex[0];
  assign hex1    = r_hex[1];
  assign hex2    = r_hex[2];
  assign hex3    = r_hex[3];
  assign hex4    = r_hex[4];
  assign hex5    = r_hex[5];

endmodule
